// File: rtl/mul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mul_sched_pkg
// Purpose : Shared types and constants for the multiplier scheduler.
//           - mul_state_t : scheduler FSM encoding (IDLE -> BUSY -> DONE)
//           - ACC_W       : width of the multiplier accuracy control
//           - ACC_MAX     : accuracy code for an exact product
// Revision: 1.0  initial release
// ============================================================================
package mul_sched_pkg;

  localparam int ACC_W = 7;
  localparam logic [ACC_W-1:0] ACC_MAX = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

endpackage : mul_sched_pkg
`default_nettype wire

// File: rtl/mul_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin selector. Picks the first asserted
//           request at or after the pointer position, wrapping around.
// Ports   : req_i  [N_REQ]          request vector
//           ptr_i  [$clog2(N_REQ)]  highest-priority position (< N_REQ)
//           gnt_o  [N_REQ]          one-hot grant, zero when no request
//           id_o   [$clog2(N_REQ)]  encoded index of the grant
//           any_o                   at least one request present
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] id_o,
  output logic                     any_o
);

  localparam int c_IDW = $clog2(N_REQ);

  int w_idx;

  // Walk from the lowest-priority slot towards the pointer; the last hit
  // overwrites earlier ones, so the nearest request to the pointer wins.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    w_idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(ptr_i) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (req_i[w_idx]) begin
        gnt_o        = '0;
        gnt_o[w_idx] = 1'b1;
        id_o         = c_IDW'(w_idx);
        any_o        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
// Module  : mul_sched
// Purpose : Time-shares one external approximate WORD_SIZE x WORD_SIZE
//           multiplier among N_REQ requesters. Round-robin grant, operand and
//           accuracy latching, fixed-latency result capture, tagged response.
//           Holds a programmable accuracy code per requester.
// Ports   : clk, rst                       clock / synchronous active-high reset
//           req_valid/req_ready            per-requester handshake (ready one-hot)
//           req_a/req_b                    packed operands, slot i at [i*W +: W]
//           cfg_we/cfg_id/cfg_acc          accuracy register write port
//           mul_a/mul_b/mul_acc            registered drive to the multiplier
//           mul_out                        product returned by the multiplier
//           rsp_valid/rsp_ready            response handshake
//           rsp_id/rsp_data                owner tag and 2*W-bit product
//           busy                           scheduler not idle
// Config  : MUL_SCHED_STATS_EN adds stat_ops (per-requester completed-op
//           counters, wrapping) and stat_stall (saturating count of cycles
//           with an unserved request).
// Revision: 1.0  initial release
// ============================================================================
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int               WORD_SIZE = 8,
  parameter int               N_REQ     = 2,
  parameter int               MUL_LAT   = 2,
  parameter logic [ACC_W-1:0] ACC_RST   = ACC_MAX
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*WORD_SIZE-1:0]     req_a,
  input  logic [N_REQ*WORD_SIZE-1:0]     req_b,
  input  logic                           cfg_we,
  input  logic [$clog2(N_REQ)-1:0]       cfg_id,
  input  logic [ACC_W-1:0]               cfg_acc,
  output logic [WORD_SIZE-1:0]           mul_a,
  output logic [WORD_SIZE-1:0]           mul_b,
  output logic [ACC_W-1:0]               mul_acc,
  input  logic [2*WORD_SIZE-1:0]         mul_out,
  output logic                           rsp_valid,
  output logic [$clog2(N_REQ)-1:0]       rsp_id,
  output logic [2*WORD_SIZE-1:0]         rsp_data,
  input  logic                           rsp_ready,
  output logic                           busy
`ifdef MUL_SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0]            stat_ops,
  output logic [15:0]                    stat_stall
`endif
);

  localparam int                c_IDW    = $clog2(N_REQ);
  localparam int                c_CNT_W  = 4;
  localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(MUL_LAT - 1);
  localparam logic [c_IDW:0]    c_NREQ   = (c_IDW + 1)'(N_REQ);
  localparam logic [c_IDW-1:0]  c_LAST   = c_IDW'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  mul_state_t                 state_q, state_d;
  logic [c_IDW-1:0]           ptr_q;
  logic [c_CNT_W-1:0]         cnt_q;
  logic [ACC_W-1:0]           acc_q [N_REQ];
  logic [WORD_SIZE-1:0]       mul_a_q, mul_b_q;
  logic [ACC_W-1:0]           mul_acc_q;
  logic                       rsp_valid_q;
  logic [c_IDW-1:0]           rsp_id_q;
  logic [2*WORD_SIZE-1:0]     rsp_data_q;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0] gnt;
  logic [c_IDW-1:0] gnt_id;
  logic             gnt_any;
  logic             grant;
  logic             capture;
  logic             handshake;
  logic             cfg_hit;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .id_o  (gnt_id),
    .any_o (gnt_any)
  );

  // --------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grant     = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Grant is withheld while reset is asserted so nothing is accepted
        // on an edge that will discard it anyway.
        if (!rst) req_ready = gnt;
        if (gnt_any) begin
          grant   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          handshake = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Accuracy registers. A write in the grant cycle lands after the grant has
  // already sampled the old value, so the launched op is unaffected.
  // --------------------------------------------------------------------------
  assign cfg_hit = cfg_we && ({1'b0, cfg_id} < c_NREQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) acc_q[i] <= ACC_RST;
    end else if (cfg_hit) begin
      acc_q[cfg_id] <= cfg_acc;
    end
  end

  // --------------------------------------------------------------------------
  // Operation launch, latency count and result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_acc_q   <= ACC_RST;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (grant) begin
        mul_a_q   <= req_a[int'(gnt_id)*WORD_SIZE +: WORD_SIZE];
        mul_b_q   <= req_b[int'(gnt_id)*WORD_SIZE +: WORD_SIZE];
        mul_acc_q <= acc_q[gnt_id];
        rsp_id_q  <= gnt_id;
        cnt_q     <= c_LAT_M1;
        ptr_q     <= (gnt_id == c_LAST) ? '0 : gnt_id + 1'b1;
      end
      if (state_q == S_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        rsp_data_q  <= mul_out;
        rsp_valid_q <= 1'b1;
      end
      if (handshake) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_acc   = mul_acc_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MUL_SCHED_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  logic [15:0] ops_q [N_REQ];
  logic [15:0] stall_q;
  logic        stall_now;

  assign stall_now = |(req_valid & ~req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) ops_q[i] <= '0;
      stall_q <= '0;
    end else begin
      // Natural 16-bit wrap on the op counters.
      if (handshake) ops_q[rsp_id_q] <= ops_q[rsp_id_q] + 16'd1;
      if (stall_now && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat_pack
    assign stat_ops[g*16 +: 16] = ops_q[g];
  end

  assign stat_stall = stall_q;
`endif

endmodule : mul_sched
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_sched
// Purpose : Self-checking bench for mul_sched. A behavioural model keeps the
//           round-robin pointer and accuracy table as plain integers/arrays
//           and predicts grant order, latency and product. The multiplier
//           stand-in only presents a valid product once its inputs have been
//           stable for MUL_LAT cycles.
// Revision: 1.0  initial release
// ============================================================================
module tb_mul_sched;

  localparam int         N   = 3;
  localparam int         W   = 8;
  localparam int         L   = 3;
  localparam int         IDW = 2;
  localparam logic [6:0] AR  = 7'h7F;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a = '0;
  logic [N*W-1:0]     req_b = '0;
  logic               cfg_we = 1'b0;
  logic [IDW-1:0]     cfg_id = '0;
  logic [6:0]         cfg_acc = '0;
  logic [W-1:0]       mul_a, mul_b;
  logic [6:0]         mul_acc;
  logic [2*W-1:0]     mul_out;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [2*W-1:0]     rsp_data;
  logic               rsp_ready = 1'b0;
  logic               busy;
`ifdef MUL_SCHED_STATS_EN
  logic [N*16-1:0]    stat_ops;
  logic [15:0]        stat_stall;
`endif

  mul_sched #(
    .WORD_SIZE (W),
    .N_REQ     (N),
    .MUL_LAT   (L),
    .ACC_RST   (AR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_acc   (cfg_acc),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_acc   (mul_acc),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef MUL_SCHED_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  int         ptr_m;
  logic [6:0] acc_m [N];

  // Approximate multiplier behaviour: exact at full accuracy, perturbed otherwise.
  function automatic logic [15:0] approx(input logic [7:0] a, input logic [7:0] b, input logic [6:0] acc);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    if (acc == 7'h7F) return p;
    return p ^ {9'd0, acc};
  endfunction

  // Multiplier stand-in: garbage until operands have settled for L cycles.
  int age = 0;
  always @(posedge clk) begin
    if (rst)                age <= 0;
    else if (req_ready != 0) age <= 1;
    else if (age < 1000)    age <= age + 1;
  end
  assign mul_out = (age >= L) ? approx(mul_a, mul_b, mul_acc) : 16'hBAD0;

  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr_m + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ptr_m = 0;
    for (int i = 0; i < N; i++) acc_m[i] = AR;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; cfg_we = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input logic [IDW-1:0] id, input logic [6:0] acc);
    tick();
    cfg_we = 1'b1; cfg_id = id; cfg_acc = acc;
    tick();
    cfg_we = 1'b0;
    if (int'(id) < N) acc_m[id] = acc;
  endtask

  // Drives one request set, waits for the grant and the response (consumer
  // always ready) and reports what was observed. Leaves req_valid cleared.
  task automatic run_op(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        output logic [N-1:0] gvec, output int gid, output int lat,
                        output logic [15:0] data, output int rid, output logic [6:0] acc_seen,
                        output logic [7:0] ma, output logic [7:0] mb, output bit to);
    to = 1'b0; gvec = '0; gid = -1; lat = 0; data = '0; rid = -1; acc_seen = '0; ma = '0; mb = '0;
    tick();
    req_valid = v; req_a = a; req_b = b; rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 20 && req_ready == 0; n++) begin tick(); #1; end
    if (req_ready == 0) begin to = 1'b1; req_valid = '0; return; end
    gvec = req_ready;
    for (int i = 0; i < N; i++) if (gvec[i]) gid = i;
    for (int n = 0; n < 40; n++) begin
      tick(); lat++; #1;
      if (lat == 1) begin acc_seen = mul_acc; ma = mul_a; mb = mul_b; end
      if (rsp_valid) break;
    end
    if (!rsp_valid) to = 1'b1;
    data = rsp_data;
    rid  = int'(rsp_id);
    req_valid = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_data !== 16'd0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    n_cmp++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin n_err++; $display("FAIL reset_mul_ab got %h/%h want 0/0", mul_a, mul_b); end
    n_cmp++; if (mul_acc !== AR) begin n_err++; $display("FAIL reset_mul_acc got %h want %h", mul_acc, AR); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
  endtask

  task automatic test_single();
    logic [N-1:0] gv; int gid, lat, rid; logic [15:0] d; logic [6:0] acs; logic [7:0] ma, mb; bit to;
    logic [N*W-1:0] pa, pb;
    do_reset();
    pa = '0; pb = '0; pa[7:0] = 8'd12; pb[7:0] = 8'd11;
    run_op(3'b001, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL single_timeout got timeout want response"); end
    n_cmp++; if (gv !== 3'b001) begin n_err++; $display("FAIL single_grant got %b want 001", gv); end
    n_cmp++; if (lat != L + 1) begin n_err++; $display("FAIL single_latency got %0d want %0d", lat, L + 1); end
    n_cmp++; if (rid != 0) begin n_err++; $display("FAIL single_rsp_id got %0d want 0", rid); end
    n_cmp++; if (d !== 16'd132) begin n_err++; $display("FAIL single_rsp_data got %0d want 132", d); end
    n_cmp++; if (ma !== 8'd12 || mb !== 8'd11) begin n_err++; $display("FAIL single_mul_ab got %0d/%0d want 12/11", ma, mb); end
    n_cmp++; if (acs !== AR) begin n_err++; $display("FAIL single_mul_acc got %h want %h", acs, AR); end
    ptr_m = 1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] gv; int gid, lat, rid, eg; logic [15:0] d; logic [6:0] acs; logic [7:0] ma, mb; bit to;
    logic [N*W-1:0] pa, pb;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pa = (N*W)'($urandom); pb = (N*W)'($urandom);
      eg = exp_grant(3'b011);
      run_op(3'b011, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
      n_cmp++; if (to || gid != eg || rid != eg) begin n_err++; $display("FAIL rr_grant op%0d got gid=%0d rid=%0d want %0d", k, gid, rid, eg); end
      n_cmp++; if (d !== approx(pa[eg*W +: W], pb[eg*W +: W], acc_m[eg])) begin n_err++; $display("FAIL rr_data op%0d got %h want %h", k, d, approx(pa[eg*W +: W], pb[eg*W +: W], acc_m[eg])); end
      ptr_m = (eg + 1) % N;
    end
  endtask

  task automatic test_cfg_acc();
    logic [N-1:0] gv; int gid, lat, rid; logic [15:0] d; logic [6:0] acs; logic [7:0] ma, mb; bit to;
    logic [N*W-1:0] pa, pb;
    cfg_write(2'd1, 7'd20);
    cfg_write(2'd3, 7'd5);   // out-of-range id, must have no effect
    pa = (N*W)'($urandom); pb = (N*W)'($urandom);
    run_op(3'b010, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    n_cmp++; if (acs !== 7'd20) begin n_err++; $display("FAIL cfg_acc_req1 got %0d want 20", acs); end
    n_cmp++; if (to || d !== approx(pa[15:8], pb[15:8], 7'd20)) begin n_err++; $display("FAIL cfg_data_req1 got %h want %h", d, approx(pa[15:8], pb[15:8], 7'd20)); end
    ptr_m = 2;
    run_op(3'b001, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    n_cmp++; if (acs !== AR) begin n_err++; $display("FAIL cfg_acc_req0 got %h want %h", acs, AR); end
    n_cmp++; if (to || d !== approx(pa[7:0], pb[7:0], AR)) begin n_err++; $display("FAIL cfg_data_req0 got %h want %h", d, approx(pa[7:0], pb[7:0], AR)); end
    ptr_m = 1;
  endtask

  task automatic test_coincident_cfg();
    logic [N-1:0] gv; int gid, lat, rid; logic [15:0] d; logic [6:0] acs, old_acc; logic [7:0] ma, mb; bit to;
    logic [N*W-1:0] pa, pb;
    int n;
    old_acc = acc_m[2];
    tick();
    req_valid = 3'b100; req_a = '0; req_b = '0; req_a[23:16] = 8'd200; req_b[23:16] = 8'd3;
    cfg_we = 1'b1; cfg_id = 2'd2; cfg_acc = 7'd33; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL coinc_grant got %b want 100", req_ready); end
    tick(); cfg_we = 1'b0; #1;
    acc_m[2] = 7'd33; ptr_m = 0;
    n_cmp++; if (mul_acc !== old_acc) begin n_err++; $display("FAIL coinc_mul_acc got %0d want %0d", mul_acc, old_acc); end
    for (n = 0; n < 20 && !rsp_valid; n++) begin tick(); #1; end
    n_cmp++; if (!rsp_valid || rsp_data !== approx(8'd200, 8'd3, old_acc)) begin n_err++; $display("FAIL coinc_data got v=%b %h want %h", rsp_valid, rsp_data, approx(8'd200, 8'd3, old_acc)); end
    req_valid = '0;
    pa = (N*W)'($urandom); pb = (N*W)'($urandom);
    run_op(3'b100, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    n_cmp++; if (to || acs !== 7'd33) begin n_err++; $display("FAIL coinc_next_acc got %0d want 33", acs); end
    ptr_m = 0;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d;
    logic [7:0]  a0, b0, a1, b1;
    int n;
    bit stable;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    tick();
    req_valid = 3'b001; req_a = {8'd0, a1, a0}; req_b = {8'd0, b1, b0}; rsp_ready = 1'b0;
    #1;
    for (n = 0; n < 20 && req_ready == 0; n++) begin tick(); #1; end
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL bp_grant0 got %b want 001", req_ready); end
    exp_d = approx(a0, b0, acc_m[0]);
    ptr_m = 1;
    tick(); req_valid = 3'b011; #1;
    for (n = 0; n < 20 && !rsp_valid; n++) begin tick(); #1; end
    stable = rsp_valid;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) begin cfg_we = 1'b1; cfg_id = 2'd1; cfg_acc = 7'd44; end
      else cfg_we = 1'b0;
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'd0 || req_ready !== '0 || busy !== 1'b1) stable = 1'b0;
    end
    acc_m[1] = 7'd44;
    n_cmp++; if (!stable) begin n_err++; $display("FAIL bp_hold got v=%b d=%h id=%0d rdy=%b want 1 %h 0 000", rsp_valid, rsp_data, rsp_id, req_ready, exp_d); end
    tick(); cfg_we = 1'b0; rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL bp_handshake_ready got %b want 000", req_ready); end
    tick(); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_rsp_drop got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL bp_next_grant got %b want 010", req_ready); end
    ptr_m = 2;
    tick(); #1;
    n_cmp++; if (mul_acc !== 7'd44) begin n_err++; $display("FAIL bp_cfg_in_done got %0d want 44", mul_acc); end
    for (n = 0; n < 20 && !rsp_valid; n++) begin tick(); #1; end
    n_cmp++; if (!rsp_valid || rsp_id !== 2'd1 || rsp_data !== approx(a1, b1, 7'd44)) begin n_err++; $display("FAIL bp_op1 got v=%b id=%0d d=%h want 1 1 %h", rsp_valid, rsp_id, rsp_data, approx(a1, b1, 7'd44)); end
    req_valid = '0;
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] gv; int gid, lat, rid; logic [15:0] d; logic [6:0] acs; logic [7:0] ma, mb; bit to;
    logic [N*W-1:0] pa, pb;
    bit seen;
    cfg_write(2'd1, 7'd50);
    tick();
    req_valid = 3'b010; req_a = 24'h00_5A_00; req_b = 24'h00_3C_00; rsp_ready = 1'b1;
    tick();          // now in BUSY
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = '0;
    model_reset();
    #1;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_state got busy=%b v=%b want 0 0", busy, rsp_valid); end
    n_cmp++; if (mul_a !== 8'd0 || mul_b !== 8'd0 || mul_acc !== AR) begin n_err++; $display("FAIL midrst_mul got %h %h %h want 0 0 %h", mul_a, mul_b, mul_acc, AR); end
    n_cmp++; if (rsp_id !== '0 || rsp_data !== 16'd0) begin n_err++; $display("FAIL midrst_rsp got id=%0d d=%h want 0 0", rsp_id, rsp_data); end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); #1; if (rsp_valid !== 1'b0) seen = 1'b1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL midrst_ghost_rsp got rsp_valid=1 want 0"); end
    pa = (N*W)'($urandom); pb = (N*W)'($urandom);
    run_op(3'b010, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    n_cmp++; if (to || acs !== AR) begin n_err++; $display("FAIL midrst_acc_cleared got %0d want %0d", acs, AR); end
    ptr_m = 2;
  endtask

  task automatic test_random();
    logic [N-1:0] gv, v; int gid, lat, rid, eg; logic [15:0] d, ed; logic [6:0] acs; logic [7:0] ma, mb; bit to;
    logic [N*W-1:0] pa, pb;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(IDW'($urandom_range(0, 3)), 7'($urandom));
      v = N'($urandom_range(1, (1 << N) - 1));
      pa = (N*W)'($urandom); pb = (N*W)'($urandom);
      eg = exp_grant(v);
      ed = approx(pa[eg*W +: W], pb[eg*W +: W], acc_m[eg]);
      run_op(v, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
      n_cmp++; if (to || gid != eg || rid != eg) begin n_err++; $display("FAIL rand_grant op%0d v=%b got %0d/%0d want %0d", k, v, gid, rid, eg); end
      n_cmp++; if (lat != L + 1) begin n_err++; $display("FAIL rand_latency op%0d got %0d want %0d", k, lat, L + 1); end
      n_cmp++; if (d !== ed || acs !== acc_m[eg]) begin n_err++; $display("FAIL rand_data op%0d got %h acc %0d want %h acc %0d", k, d, acs, ed, acc_m[eg]); end
      ptr_m = (eg + 1) % N;
    end
  endtask

`ifdef MUL_SCHED_STATS_EN
  task automatic test_stats();
    logic [N-1:0] gv; int gid, lat, rid; logic [15:0] d; logic [6:0] acs; logic [7:0] ma, mb; bit to;
    logic [N*W-1:0] pa, pb;
    do_reset();
    pa = (N*W)'($urandom); pb = (N*W)'($urandom);
    for (int k = 0; k < 3; k++) run_op(3'b001, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    run_op(3'b010, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    tick(); #1;
    n_cmp++; if (stat_ops !== {16'd0, 16'd1, 16'd3}) begin n_err++; $display("FAIL stats_ops got %h want %h", stat_ops, {16'd0, 16'd1, 16'd3}); end
    n_cmp++; if (stat_stall !== 16'(4 * L)) begin n_err++; $display("FAIL stats_stall got %0d want %0d", stat_stall, 4 * L); end
    run_op(3'b101, pa, pb, gv, gid, lat, d, rid, acs, ma, mb, to);
    tick(); #1;
    n_cmp++; if (stat_stall !== 16'(5 * L + 1)) begin n_err++; $display("FAIL stats_stall_multi got %0d want %0d", stat_stall, 5 * L + 1); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_cfg_acc();
    test_coincident_cfg();
    test_backpressure();
    test_reset_midop();
    test_random();
`ifdef MUL_SCHED_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mul_sched
`default_nettype wire
